// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM states and iteration count for the multiply/divide sequencer
package md_pkg;
    localparam int MD_ITER = 32;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } md_state_e;
endpackage

// File: rtl/md_step.sv
// md_step: one iteration of shift-add multiply or restoring divide on unsigned magnitudes
// Ports: is_div selects divide; acc_i/opa_i/opb_i current datapath state; *_o next state.
// Multiply: acc = product accumulator, opa = shifted multiplicand, opb = remaining multiplier.
// Divide:   acc[31:0] = partial remainder, opa[31:0] = divisor, opb = dividend shifting into quotient.
module md_step (
    input  logic        is_div,
    input  logic [63:0] acc_i,
    input  logic [63:0] opa_i,
    input  logic [31:0] opb_i,
    output logic [63:0] acc_o,
    output logic [63:0] opa_o,
    output logic [31:0] opb_o
);
    logic [32:0] rs;
    logic [32:0] diff;
    assign rs    = {acc_i[31:0], opb_i[31]};
    // remainder stays below divisor, so bit 32 of diff is a clean borrow flag
    assign diff  = rs - {1'b0, opa_i[31:0]};
    assign acc_o = is_div ? {32'b0, diff[32] ? rs[31:0] : diff[31:0]}
                          : acc_i + (opb_i[0] ? opa_i : 64'd0);
    assign opa_o = is_div ? opa_i : opa_i << 1;
    assign opb_o = is_div ? {opb_i[30:0], ~diff[32]} : opb_i >> 1;
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Ports: clk, reset (async active-low); mdstartE/mdopE/srcaE/srcbE start an op; flushE aborts;
//        hiweE/loweE/hilowdE are MTHI/MTLO writes (honoured only when idle);
//        mdrunE busy, mddone commit pulse, divzero with mddone on zero divisor, hi/lo registers.
// Config: define MD_EARLY_OUT_EN to stop multiplies once the remaining multiplier is zero.
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mdstartE,
    input  logic [1:0]       mdopE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    input  logic             hiweE,
    input  logic             loweE,
    input  logic [WIDTH-1:0] hilowdE,
    output logic             mdrunE,
    output logic             mddone,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif
    localparam logic [4:0] CNT_LAST = 5'(MD_ITER - 1);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] acc_q, acc_d, opa_q, opa_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic        is_div, is_signed, sa, sb, busy;
    logic [31:0] mag_a, mag_b, res_hi, res_lo;
    logic [63:0] prod, acc_s, opa_s;
    logic [31:0] opb_s;

    assign is_div    = op_q inside {OP_DIV, OP_DIVU};
    assign is_signed = op_q inside {OP_MULT, OP_DIV};
    assign sa        = is_signed & a_q[31];
    assign sb        = is_signed & b_q[31];
    assign mag_a     = sa ? -a_q : a_q;
    assign mag_b     = sb ? -b_q : b_q;
    assign busy      = state_q inside {S_PREP, S_RUN, S_FIX};
    assign prod      = neg_q ? -acc_q : acc_q;
    // quotient sign is the xor of operand signs; remainder sign follows the dividend
    assign res_lo    = is_div ? (neg_q ? -opb_q : opb_q) : prod[31:0];
    assign res_hi    = is_div ? (rneg_q ? -acc_q[31:0] : acc_q[31:0]) : prod[63:32];

    md_step u_step (
        .is_div (is_div),
        .acc_i  (acc_q),
        .opa_i  (opa_q),
        .opb_i  (opb_q),
        .acc_o  (acc_s),
        .opa_o  (opa_s),
        .opb_o  (opb_s)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = (mdstartE && !flushE) ? S_PREP : S_IDLE;
                if (mdstartE && !flushE) begin
                    op_d = md_op_e'(mdopE);
                    a_d  = srcaE;
                    b_d  = srcbE;
                end
            end
            S_PREP: begin
                acc_d  = 64'd0;
                opa_d  = {32'b0, is_div ? mag_b : mag_a};
                opb_d  = is_div ? mag_a : mag_b;
                neg_d  = sa ^ sb;
                rneg_d = sa;
                cnt_d  = 5'd0;
                state_d = S_RUN;
                if (is_div && b_q == 32'd0) begin
                    state_d = S_DONE;
                    hi_d    = a_q;
                    lo_d    = '1;
                    dz_d    = 1'b1;
                end else if (EARLY_OUT && !is_div && mag_b == 32'd0) begin
                    state_d = S_FIX;
                end
            end
            S_RUN: begin
                acc_d = acc_s;
                opa_d = opa_s;
                opb_d = opb_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST || (EARLY_OUT && !is_div && opb_s == 32'd0)) begin
                    state_d = S_FIX;
                    cnt_d   = 5'd0;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                hi_d    = res_hi;
                lo_d    = res_lo;
                dz_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (flushE && busy) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dz_d    = 1'b0;
        end
        // MTHI/MTLO take priority over any commit on the same edge
        if (hiweE && !busy) hi_d = hilowdE;
        if (loweE && !busy) lo_d = hilowdE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdrunE  = busy;
    assign mddone  = state_q == S_DONE;
    assign divzero = mddone & dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: randomized and directed checks of md_sequencer against an arithmetic reference model
module tb_md_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        mdstartE, flushE, hiweE, loweE;
    logic [1:0]  mdopE;
    logic [31:0] srcaE, srcbE, hilowdE;
    logic        mdrunE, mddone, divzero;
    logic [31:0] hi, lo;
    int          n_chk = 0;
    int          n_err = 0;

    md_sequencer #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .mdstartE(mdstartE),
        .mdopE   (mdopE),
        .srcaE   (srcaE),
        .srcbE   (srcbE),
        .flushE  (flushE),
        .hiweE   (hiweE),
        .loweE   (loweE),
        .hilowdE (hilowdE),
        .mdrunE  (mdrunE),
        .mddone  (mddone),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: results from plain 64-bit arithmetic; latency from the cycle rules.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic dz, output int cyc);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dz  = 1'b0;
        cyc = 35;
        h   = '0;
        l   = '0;
        if (op[1]) begin
            if (b == 32'd0) begin
                h = a; l = '1; dz = 1'b1; cyc = 2;
            end else if (op == 2'b10) begin
                q = sa / sb; r = sa % sb;
                l = q[31:0]; h = r[31:0];
            end else begin
                l = a / b; h = a % b;
            end
        end else begin
            p = (op == 2'b00) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
            {h, l} = p;
`ifdef MD_EARLY_OUT_EN
            begin
                logic [31:0] m;
                m   = (op == 2'b00 && b[31]) ? -b : b;
                cyc = 3;
                for (int i = 0; i < 32; i++) if (m[i]) cyc = i + 4;
            end
`endif
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edz;
        int          ecyc, cyc;
        bit          busy_ok;
        model(op, a, b, eh, el, edz, ecyc);
        mdopE = op; srcaE = a; srcbE = b; mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0; srcaE = $urandom; srcbE = $urandom;
        cyc = 1;
        check("busy_c1", mdrunE, 1);
        busy_ok = 1;
        while (!mddone && cyc < 80) begin
            if (!mdrunE) busy_ok = 0;
            tick();
            cyc++;
        end
        check("busy_until_done", busy_ok, 1);
        check("done_cycle", cyc, ecyc);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("divzero", divzero, edz);
        check("idle_in_done", mdrunE, 0);
        tick();
        check("done_pulse", mddone, 0);
        check("divzero_clr", divzero, 0);
        check("hi_hold", hi, eh);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit no_done;
        reset = 1'b0; mdstartE = 1'b0; flushE = 1'b0; hiweE = 1'b0; loweE = 1'b0;
        mdopE = 2'b00; srcaE = '0; srcbE = '0; hilowdE = '0;
        repeat (3) tick();
        check("rst_run", mdrunE, 0);
        check("rst_done", mddone, 0);
        check("rst_dz", divzero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b1;
        tick();

        run_op(2'b01, 32'd3, 32'd5);
        check("multu_lo", lo, 32'h0000_000F);
        check("multu_hi", hi, 32'h0);
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd10, 32'd0);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'h0000_000A);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        run_op(2'b00, 32'd77, 32'd0);

        hiweE = 1'b1; hilowdE = 32'h0000_AAAA;
        tick();
        hiweE = 1'b0; loweE = 1'b1; hilowdE = 32'h0000_5555;
        tick();
        loweE = 1'b0;
        check("mthi", hi, 32'h0000_AAAA);
        check("mtlo", lo, 32'h0000_5555);

        mdstartE = 1'b1; flushE = 1'b1; mdopE = 2'b01; srcaE = 32'd3; srcbE = 32'd5;
        tick();
        mdstartE = 1'b0; flushE = 1'b0;
        check("flush_prio", mdrunE, 0);

        mdopE = 2'b01; srcaE = 32'd3; srcbE = 32'hFFFF_FFFF; mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        flushE = 1'b1; hiweE = 1'b1; hilowdE = 32'h0000_1234;
        tick();
        flushE = 1'b0; hiweE = 1'b0;
        check("flush_run", mdrunE, 0);
        check("flush_done", mddone, 0);
        check("flush_hi", hi, 32'h0000_AAAA);
        check("flush_lo", lo, 32'h0000_5555);
        no_done = 1;
        for (int c = 0; c < 40; c++) begin
            if (mddone || mdrunE) no_done = 0;
            tick();
        end
        check("flush_quiet", no_done, 1);

        mdopE = 2'b01; srcaE = 32'd7; srcbE = 32'hFFFF_FFFF; mdstartE = 1'b1;
        tick();
        mdstartE = 1'b0;
        repeat (14) tick();
        #2 reset = 1'b0;
        #1;
        check("arst_run", mdrunE, 0);
        check("arst_done", mddone, 0);
        check("arst_dz", divzero, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        #3 reset = 1'b1;
        tick();
        run_op(2'b01, 32'd3, 32'd5);

        for (int k = 0; k < 40; k++) run_op(2'($urandom_range(0, 3)), pick(), pick());

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
